muxn_arb: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake, for the MIPS datapath and its peripherals. It generalises the 32:1 single-bit combinational mux to N channels of W bits, with a one-entry output register and back-pressure. It supports two modes: explicit select by `sel`, or arbitration among all requesting channels. It sits between multiple producers (register read ports, bus masters) and a single consumer.

---
 rtl/muxn_pkg.sv | 12 +
 rtl/muxn_rr_pick.sv | 37 +++
 rtl/muxn_arb.sv | 127 ++++++++++++
 tb/tb_muxn_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared types and default sizing for the N-channel registered mux/arbiter.
package muxn_pkg;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_ARB    = 1'b1
  } muxn_mode_t;

  localparam int unsigned MUXN_N_DEF = 32;
  localparam int unsigned MUXN_W_DEF = 32;

endpackage

// File: rtl/muxn_rr_pick.sv
// Round-robin picker: the first requester at or above ptr wins, else the lowest requester overall.
module muxn_rr_pick #(
  parameter  int unsigned N    = 32,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  logic            w_hi_v;
  logic            w_lo_v;
  logic [SELW-1:0] w_hi_idx;
  logic [SELW-1:0] w_lo_idx;

  // Scanning downward leaves the lowest qualifying index in each candidate.
  always_comb begin
    w_hi_v   = 1'b0;
    w_lo_v   = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_v   = 1'b1;
        w_lo_idx = SELW'(i);
        if (SELW'(i) >= ptr) begin
          w_hi_v   = 1'b1;
          w_hi_idx = SELW'(i);
        end
      end
    end
    grant_valid = w_lo_v;
    grant_idx   = w_hi_v ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/muxn_arb.sv
// N-channel W-bit registered mux with valid/ready handshake, explicit select or arbitration.
// Define MUXN_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module muxn_arb
  import muxn_pkg::*;
#(
  parameter  int unsigned N    = MUXN_N_DEF,
  parameter  int unsigned W    = MUXN_W_DEF,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic [N-1:0]        in_valid,
  input  logic [N-1:0][W-1:0] in_data,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SELW-1:0]     out_sel,
  input  logic                out_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [W-1:0]    r_data;
  logic [W-1:0]    w_data_nxt;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] w_sel_nxt;

  logic            w_load;
  logic            w_sel_ok;
  logic            w_arb_v;
  logic [SELW-1:0] w_arb_idx;
  logic            w_grant;
  logic [SELW-1:0] w_gidx;
  logic            w_take;

  // Out-of-range select indices are filtered before indexing in_valid.
  assign w_sel_ok = (32'(sel) < N) && in_valid[sel];

`ifdef MUXN_RR_EN
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_ptr_nxt;

  muxn_rr_pick #(.N(N)) u_pick (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant_valid (w_arb_v),
    .grant_idx   (w_arb_idx)
  );

  // Pointer moves past every accepted grant, whichever mode produced it.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_take) begin
      w_ptr_nxt = (w_gidx == SELW'(N - 1)) ? '0 : w_gidx + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  // Fixed priority: downward scan leaves the lowest valid index.
  always_comb begin
    w_arb_v   = 1'b0;
    w_arb_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_arb_v   = 1'b1;
        w_arb_idx = SELW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_grant = w_sel_ok;
    w_gidx  = sel;
    if (muxn_mode_t'(mode) == MODE_ARB) begin
      w_grant = w_arb_v;
      w_gidx  = w_arb_idx;
    end
  end

  assign w_load   = (r_state == ST_EMPTY) | out_ready;
  assign w_take   = w_load & w_grant & ~rst;
  assign in_ready = w_take ? (N'(1) << w_gidx) : '0;

  // Output stage: load on accept, empty on an idle load slot, otherwise hold.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    if (w_take) begin
      w_state_nxt = ST_FULL;
      w_data_nxt  = in_data[w_gidx];
      w_sel_nxt   = w_gidx;
    end else if (w_load) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb: a queue-based model predicts grants and output items.
module tb_muxn_arb;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int N2 = 20;
  localparam int W2 = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                mode;
  logic [4:0]          sel;
  logic [N-1:0]        in_valid;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]        in_ready;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic [4:0]          out_sel;
  logic                out_ready;

  logic                  mode2;
  logic [4:0]            sel2;
  logic [N2-1:0]         in_valid2;
  logic [N2-1:0][W2-1:0] in_data2;
  logic [N2-1:0]         in_ready2;
  logic                  out_valid2;
  logic [W2-1:0]         out_data2;
  logic [4:0]            out_sel2;
  logic                  out_ready2;

  always #5 clk = ~clk;

  muxn_arb #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  muxn_arb #(.N(N2), .W(W2)) u_dut20 (
    .clk(clk), .rst(rst), .mode(mode2), .sel(sel2),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_sel(out_sel2),
    .out_ready(out_ready2)
  );

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } item_t;

  item_t sb[$];
  int    glog[$];
  int    n_chk  = 0;
  int    n_err  = 0;
  int    n_push = 0;
  int    n_pop  = 0;
  int    n_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output register occupancy, arbitration pointer, predicted grants.
  bit           m_full = 1'b0;
  int           m_ptr  = 0;
  bit           m_gv;
  bit           m_load;
  int           m_g;
  int           m_j;
  logic [N-1:0] m_exp;
  item_t        m_it;

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
      n_drop += sb.size();
      sb.delete();
      m_full = 1'b0;
      m_ptr  = 0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_full));
      m_load = !m_full || out_ready;
      m_gv   = 1'b0;
      m_g    = 0;
      if (mode == 1'b0) begin
        if (int'(sel) < N && in_valid[sel]) begin
          m_gv = 1'b1;
          m_g  = int'(sel);
        end
      end else begin
        for (int k = 0; k < N; k++) begin
`ifdef MUXN_RR_EN
          m_j = (m_ptr + k) % N;
`else
          m_j = k;
`endif
          if (!m_gv && in_valid[m_j]) begin
            m_gv = 1'b1;
            m_g  = m_j;
          end
        end
      end
      m_exp = '0;
      if (m_load && m_gv) m_exp[m_g] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(m_exp));
      if (m_load && m_gv) begin
        m_it.d = in_data[m_g];
        m_it.s = m_g;
        sb.push_back(m_it);
        glog.push_back(m_g);
        n_push++;
        m_full = 1'b1;
        m_ptr  = (m_g + 1) % N;
      end else if (m_load) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: every item the consumer takes must be the oldest predicted item.
  item_t mon_it;
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_item", 64'(out_sel), 64'hFFFF);
      end else begin
        mon_it = sb.pop_front();
        n_pop++;
        chk("out_data", 64'(out_data), 64'(mon_it.d));
        chk("out_sel", 64'(out_sel), 64'(mon_it.s));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_order[6];
  logic [W-1:0] held;

  initial begin
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = '1; in_data = '0; out_ready = 1'b1;
    mode2 = 1'b0; sel2 = '0; in_valid2 = '0; in_data2 = '0; out_ready2 = 1'b1;
    step(); step();
    rst = 1'b0; in_valid = '0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_sel", 64'(out_sel), 64'd0);
    step();

    // Select sweep with all channels valid.
    for (int i = 0; i < N; i++) in_data[i] = 32'hA500_0000 + 32'(i);
    in_valid = '1; mode = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < N; s++) begin
      sel = 5'(s);
      step();
    end
    in_valid = '0;
    step(); step();

    // Back-pressure: hold FULL for three cycles with a second item waiting.
    sel = 5'd4; in_valid = 32'h10; in_data[4] = 32'hBEEF_0004; out_ready = 1'b0;
    step();
    sel = 5'd5; in_valid = 32'h20; in_data[5] = 32'hCAFE_0005;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_data", 64'(out_data), 64'hBEEF_0004);
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = '0;
    step(); step();

    // Arbitration order from a freshly reset pointer.
    rst = 1'b1; step(); rst = 1'b0;
    glog.delete();
    mode = 1'b1; in_valid = 32'h8000_0005; out_ready = 1'b1;
    repeat (6) step();
    in_valid = '0;
    step();
`ifdef MUXN_RR_EN
    exp_order = '{0, 2, 31, 0, 2, 31};
`else
    exp_order = '{0, 0, 0, 0, 0, 0};
`endif
    chk("arb_grant_count", 64'(glog.size()), 64'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk("arb_grant_order", 64'(glog[k]), 64'(exp_order[k]));
    step();

    // Reset while FULL and stalled discards the held item.
    mode = 1'b0; sel = 5'd7; in_valid = 32'h80; in_data[7] = 32'h1234_5677; out_ready = 1'b0;
    step();
    rst = 1'b1; in_valid = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data", 64'(out_data), 64'd0);
    chk("rst_mid_sel", 64'(out_sel), 64'd0);
    step();
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    @(negedge clk);
    chk("first_grant_after_rst", 64'(in_ready), 64'd1);
    step();
    in_valid = '0;
    step(); step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      mode = 1'($urandom_range(0, 1));
      sel = 5'($urandom_range(0, 31));
      in_valid = ($urandom_range(0, 7) == 0) ? '0 : ($urandom & $urandom);
      for (int i = 0; i < N; i++) in_data[i] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0; out_ready = 1'b1;
    step(); step();

    // Non-power-of-two channel count with an out-of-range select.
    sel2 = 5'd3; in_valid2 = '1; in_data2[3] = 8'h3C; out_ready2 = 1'b0;
    step();
    sel2 = 5'd25;
    @(negedge clk);
    chk("n20_full_valid", 64'(out_valid2), 64'd1);
    chk("n20_full_sel", 64'(out_sel2), 64'd3);
    chk("n20_full_data", 64'(out_data2), 64'h3C);
    chk("n20_ready_stall", 64'(in_ready2), 64'd0);
    step();
    out_ready2 = 1'b1;
    @(negedge clk);
    chk("n20_ready_badsel", 64'(in_ready2), 64'd0);
    step();
    @(negedge clk);
    chk("n20_drained", 64'(out_valid2), 64'd0);
    chk("n20_ready_after", 64'(in_ready2), 64'd0);
    chk("n20_data_holds", 64'(out_data2), 64'h3C);
    step();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("items_conserved", 64'(n_push), 64'(n_pop + n_drop));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
